// File: rtl/ysyx_npc_core_pkg.sv
// Shared constants and decode types for the single-cycle RV64I bring-up core.
// Pure declarations; no timing or flow control.
package ysyx_npc_core_pkg;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ADDI,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_EBREAK
  } cls_t;

  typedef struct packed {
    cls_t            cls;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
  } dec_t;

endpackage

// File: rtl/ysyx_npc_core_exu.sv
// ALU, next-PC, register write-back and sticky halt flag.
// Results commit on the same edge as the PC update; no backpressure.
module ysyx_npc_core_exu
  import ysyx_npc_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  dec_t            dec,
  output logic [XLEN-1:0] dnpc,
  output logic            halt
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] unused_rs2_val;
  logic            wr_en;
  logic [XLEN-1:0] wr_dat;
  logic            halt_set;
  logic [XLEN-1:0] jalr_tgt;

  ysyx_npc_core_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (dec.rs1),
    .raddr2 (dec.rs2),
    .rdata1 (rs1_val),
    .rdata2 (unused_rs2_val),
    .we     (wr_en && !halt),
    .waddr  (dec.rd),
    .wdata  (wr_dat)
  );

  assign jalr_tgt = rs1_val + dec.imm_i;

  always_comb begin
    dnpc     = pc + 64'd4;
    wr_en    = 1'b0;
    wr_dat   = '0;
    halt_set = 1'b0;
    unique case (dec.cls)
      CLS_ADDI:   begin wr_en = 1'b1; wr_dat = jalr_tgt; end
      CLS_LUI:    begin wr_en = 1'b1; wr_dat = dec.imm_u; end
      CLS_AUIPC:  begin wr_en = 1'b1; wr_dat = pc + dec.imm_u; end
      CLS_JAL:    begin wr_en = 1'b1; wr_dat = pc + 64'd4; dnpc = pc + dec.imm_j; end
      CLS_JALR:   begin wr_en = 1'b1; wr_dat = pc + 64'd4; dnpc = {jalr_tgt[XLEN-1:1], 1'b0}; end
      // PC parks on the EBREAK address so it stays there once halted.
      CLS_EBREAK: begin halt_set = 1'b1; dnpc = pc; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt <= 1'b0;
    end else if (halt_set) begin
      halt <= 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_npc_core_idu.sv
// Combinational instruction decode: register fields, immediates, class.
// Zero latency; no backpressure.
module ysyx_npc_core_idu
  import ysyx_npc_core_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [9:0] opcode;

  assign opcode = {inst[14:12], inst[6:0]};

  always_comb begin
    dec.rd    = inst[11:7];
    dec.rs1   = inst[19:15];
    dec.rs2   = inst[24:20];
    dec.imm_i = {{52{inst[31]}}, inst[31:20]};
    dec.imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
    dec.imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // EBREAK is a full-word match; any other SYSTEM encoding falls to NOP.
    if (inst == EBREAK_WORD)                    dec.cls = CLS_EBREAK;
    else if (opcode == {3'b000, OP_IMM})        dec.cls = CLS_ADDI;
    else if (opcode[6:0] == OP_LUI)             dec.cls = CLS_LUI;
    else if (opcode[6:0] == OP_AUIPC)           dec.cls = CLS_AUIPC;
    else if (opcode[6:0] == OP_JAL)             dec.cls = CLS_JAL;
    else if (opcode == {3'b000, OP_JALR})       dec.cls = CLS_JALR;
    else                                        dec.cls = CLS_NOP;
  end

endmodule

// File: rtl/ysyx_npc_core_ifu.sv
// PC register with reset load and halt freeze.
// Updates on every non-halted edge; no backpressure.
module ysyx_npc_core_ifu
  import ysyx_npc_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] dnpc,
  input  logic            halt,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (!halt) begin
      pc <= dnpc;
    end
  end

endmodule

// File: rtl/ysyx_npc_core_regfile.sv
// 32 x XLEN register file, two combinational reads, one write; x0 hardwired to 0.
// Write commits on the clock edge; no backpressure.
module ysyx_npc_core_regfile
  import ysyx_npc_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/ysyx_npc_core.sv
// Single-cycle RV64I bring-up core (ADDI/LUI/AUIPC/JAL/JALR/EBREAK), halts on EBREAK.
// One instruction retires per edge from the combinational inst at pc; no backpressure.
module ysyx_npc_core
  import ysyx_npc_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            halt
);

  dec_t            dec;
  logic [XLEN-1:0] dnpc;

  ysyx_npc_core_ifu u_ifu (
    .clk  (clk),
    .rst  (rst),
    .dnpc (dnpc),
    .halt (halt),
    .pc   (pc)
  );

  ysyx_npc_core_idu u_idu (
    .inst (inst),
    .dec  (dec)
  );

  ysyx_npc_core_exu u_exu (
    .clk  (clk),
    .rst  (rst),
    .pc   (pc),
    .dec  (dec),
    .dnpc (dnpc),
    .halt (halt)
  );

endmodule

// File: tb/tb_ysyx_npc_core.sv
// Scoreboard bench: driver runs an ISA-level model and queues expected pc/halt;
// a monitor pops and compares after every clock edge and reset assertion.
module tb_ysyx_npc_core;

  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam logic [31:0] EBRK  = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        halt;

  ysyx_npc_core dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst),
    .pc   (pc),
    .halt (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  logic [63:0] m_x [32];
  logic [63:0] m_pc;
  logic        m_halt;

  task automatic chk(input bit ok, input string what);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @%0t: pc=%h halt=%b", what, $time, pc, halt);
    end
  endtask

  // Monitor: one expectation per rising edge and per reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc || halt !== e.halt) begin
          n_bad++;
          $display("FAIL state @%0t: got pc=%h halt=%b, expected pc=%h halt=%b",
                   $time, pc, halt, e.pc, e.halt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    chk(done, "timeout waiting for test completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic void push_exp();
    exp_t e;
    e.pc   = m_pc;
    e.halt = m_halt;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
    m_pc   = 64'h8000_0000;
    m_halt = 1'b0;
  endfunction

  // Architectural effect of one instruction word, straight from the ISA rules.
  function automatic void model_exec(input logic [31:0] w);
    logic [63:0] imm_i, imm_u, imm_j, a, val, nxt;
    logic        wr;
    if (m_halt) return;
    imm_i = {{52{w[31]}}, w[31:20]};
    imm_u = {{32{w[31]}}, w[31:12], 12'h000};
    imm_j = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    a     = m_x[w[19:15]];
    nxt   = m_pc + 64'd4;
    wr    = 1'b0;
    val   = 64'd0;
    if (w == EBRK) begin
      m_halt = 1'b1;
      nxt    = m_pc;
    end else if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) begin
      wr = 1'b1; val = a + imm_i;
    end else if (w[6:0] == 7'b0110111) begin
      wr = 1'b1; val = imm_u;
    end else if (w[6:0] == 7'b0010111) begin
      wr = 1'b1; val = m_pc + imm_u;
    end else if (w[6:0] == 7'b1101111) begin
      wr = 1'b1; val = m_pc + 64'd4; nxt = m_pc + imm_j;
    end else if (w[6:0] == 7'b1100111 && w[14:12] == 3'b000) begin
      wr = 1'b1; val = m_pc + 64'd4; nxt = (a + imm_i) & ~64'd1;
    end
    if (wr && w[11:7] != 5'd0) m_x[w[11:7]] = val;
    m_pc = nxt;
  endfunction

  // Entered just after a rising edge; returns just after the next one.
  task automatic step(input logic [31:0] w);
    inst = w;
    model_exec(w);
    push_exp();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, holds it across one edge, releases it mid-cycle.
  task automatic do_reset();
    #3;
    model_reset();
    push_exp();
    rst = 1'b0;
    push_exp();
    #1;
    chk(pc === 64'h8000_0000 && halt === 1'b0, "reset state");
    @(posedge clk);
    #1;
    #2;
    rst = 1'b1;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r, w;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    w = {r[31:15], 3'b000, r[11:7], 7'b0010011};
      2:       w = {r[31:7], 7'b0110111};
      3:       w = {r[31:7], 7'b0010111};
      4:       w = {r[31:7], 7'b1101111};
      5:       w = {r[31:15], 3'b000, r[11:7], 7'b1100111};
      6:       w = {r[31:15], 3'b001, r[11:7], 7'b1100111};
      7:       w = {r[31:15], r[14:12], r[11:7], 7'b0010011};
      8:       w = r;
      default: w = NOP_W;
    endcase
    if (w == EBRK) w = NOP_W;
    return w;
  endfunction

  initial begin
    logic [63:0] halt_pc;
    rst  = 1'b1;
    inst = NOP_W;
    model_reset();
    @(posedge clk);
    #1;

    do_reset();
    step(NOP_W);
    step(NOP_W);

    do_reset();
    step(32'h1000_0093);
    step(32'h0000_8067);
    step(32'hfff0_0093);
    step(32'h0010_8067);
    step(32'h8000_0137);
    step(32'h0001_0067);

    do_reset();
    step(32'h0080_00ef);
    step(32'h0000_8067);

    do_reset();
    step(32'h0000_1197);
    step(32'h0001_8067);
    step(32'h0050_0013);
    step(32'h0000_0067);

    step(EBRK);
    halt_pc = pc;
    for (int i = 0; i < 10; i++) begin
      step($urandom);
      chk(halt === 1'b1 && pc === halt_pc, "halt frozen");
    end
    do_reset();
    step(NOP_W);

    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 399) do_reset();
      step(gen_inst());
    end
    step(EBRK);
    for (int i = 0; i < 5; i++) step(gen_inst());

    #2;
    chk(exp_q.size() == 0, "expectation queue drained");
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
